// File: rtl/sd_pkg.sv
// sd_pkg: shared constants and types for the SD single-block read path.
//   - SD SPI protocol bytes (CMD17 opcode, data start token, idle fill byte)
//   - Controller state enumeration and error-code encoding
//   - Word-address width of the boot memory port
//   - cmd_byte(): selects the n-th byte of a CMD17 frame
package sd_pkg;

  localparam logic [7:0] CMD17_OP    = 8'h51;
  localparam logic [7:0] START_TOKEN = 8'hFE;
  localparam logic [7:0] IDLE_BYTE   = 8'hFF;

  // Boot memory word index width (512-byte sector = 128 words).
  localparam int WORD_AW = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_R1_WAIT,
    ST_TOKEN_WAIT,
    ST_DATA,
    ST_CRC,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'b00,
    ERR_R1_TIMEOUT = 2'b01,
    ERR_R1_NONZERO = 2'b10,
    ERR_TOKEN      = 2'b11
  } err_code_t;

  // CMD17 frame: opcode, 32-bit block address MSB first, then CRC/stop byte.
  function automatic logic [7:0] cmd_byte(input logic [2:0]  idx,
                                          input logic [31:0] addr,
                                          input logic [7:0]  crc);
    logic [7:0] b;
    case (idx)
      3'd0:    b = CMD17_OP;
      3'd1:    b = addr[31:24];
      3'd2:    b = addr[23:16];
      3'd3:    b = addr[15:8];
      3'd4:    b = addr[7:0];
      3'd5:    b = crc;
      default: b = IDLE_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sd_word_packer.sv
// sd_word_packer: collects received sector bytes into 32-bit words, MSB first,
// and emits one memory write per four bytes.
//   clk, rst     clock and synchronous active-high reset
//   clr          synchronous clear at the start of a new request
//   byte_vld     one-cycle strobe, byte_in holds a payload byte
//   byte_in      payload byte
//   mem_we       one-cycle word write strobe (cycle after the 4th byte)
//   mem_addr     word index of the word being written
//   mem_data     packed word; first byte of the group in [31:24]
module sd_word_packer
  import sd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               byte_vld,
  input  logic [7:0]         byte_in,
  output logic               mem_we,
  output logic [WORD_AW-1:0] mem_addr,
  output logic [31:0]        mem_data
);

  logic [23:0]        shift_p0;
  logic [1:0]         lane_p0;
  logic [WORD_AW-1:0] word_idx_p0;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shift_p0    <= '0;
      lane_p0     <= '0;
      word_idx_p0 <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_data    <= '0;
    end else begin
      mem_we <= 1'b0;
      if (byte_vld) begin
        shift_p0 <= {shift_p0[15:0], byte_in};
        lane_p0  <= lane_p0 + 2'd1;
        // Fourth byte of a group completes the word; the index advances
        // only after the write so mem_addr names the word just written.
        if (lane_p0 == 2'd3) begin
          mem_we      <= 1'b1;
          mem_addr    <= word_idx_p0;
          mem_data    <= {shift_p0, byte_in};
          word_idx_p0 <= word_idx_p0 + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sd_block_reader.sv
// sd_block_reader: reads one SD sector with CMD17 over a byte-level SPI
// transceiver and writes it as 32-bit words into boot memory.
//   control_clk_i / control_rst_i  clock, synchronous active-high reset
//   rd_req_i, rd_addr_i            request and sector address (sampled in IDLE)
//   rd_busy_o, rd_done_o, rd_err_o request status; done/err are 1-cycle pulses
//   err_code_o                     01 R1 timeout, 10 R1 nonzero, 11 token
//   spi_cs_n_o, spi_start_o,       SPI transceiver control: one byte in flight,
//   spi_tx_byte_o, spi_rx_byte_i,  start pulsed one cycle after the previous
//   spi_done_i                     done (or with the state entry)
//   mem_we_o, mem_addr_o, mem_data_o  boot memory word write port
module sd_block_reader
  import sd_pkg::*;
#(
  parameter int         R1_TIMEOUT    = 8,
  parameter int         TOKEN_TIMEOUT = 4096,
  parameter int         BLOCK_BYTES   = 512,
  parameter logic [7:0] CMD17_CRC     = 8'h01
) (
  input  logic               control_clk_i,
  input  logic               control_rst_i,
  input  logic               rd_req_i,
  input  logic [31:0]        rd_addr_i,
  output logic               rd_busy_o,
  output logic               rd_done_o,
  output logic               rd_err_o,
  output logic [1:0]         err_code_o,
  output logic               spi_cs_n_o,
  output logic               spi_start_o,
  output logic [7:0]         spi_tx_byte_o,
  input  logic [7:0]         spi_rx_byte_i,
  input  logic               spi_done_i,
  output logic               mem_we_o,
  output logic [WORD_AW-1:0] mem_addr_o,
  output logic [31:0]        mem_data_o
);

  localparam int POLL_W = $clog2(TOKEN_TIMEOUT) + 1;
  // The byte counter also indexes the 6 command bytes, so keep at least 3 bits.
  localparam int BYTE_W = ($clog2(BLOCK_BYTES) > 3) ? $clog2(BLOCK_BYTES) : 3;

  localparam logic [POLL_W-1:0] R1_LAST    = POLL_W'(R1_TIMEOUT - 1);
  localparam logic [POLL_W-1:0] TOKEN_LAST = POLL_W'(TOKEN_TIMEOUT - 1);
  localparam logic [BYTE_W-1:0] DATA_LAST  = BYTE_W'(BLOCK_BYTES - 1);
  localparam logic [BYTE_W-1:0] CMD_LAST   = BYTE_W'(5);
  localparam logic [BYTE_W-1:0] CRC_LAST   = BYTE_W'(1);

  state_t            state;
  logic [31:0]       addr_lat;
  logic [BYTE_W-1:0] byte_cnt;
  logic [POLL_W-1:0] poll_cnt;
  logic              outstanding;

  logic              xfer_done;
  logic              accept;
  logic              pack_vld;
  logic [2:0]        next_cmd_idx;
  logic              fail;
  err_code_t         fail_code;

  // A done pulse only counts when this controller has a byte in flight.
  assign xfer_done    = spi_done_i & outstanding;
  assign accept       = (state == ST_IDLE) & rd_req_i;
  assign pack_vld     = (state == ST_DATA) & xfer_done;
  assign next_cmd_idx = byte_cnt[2:0] + 3'd1;

  // Response classification for the two polling states.
  always_comb begin
    fail      = 1'b0;
    fail_code = ERR_NONE;
    if (xfer_done) begin
      case (state)
        ST_R1_WAIT: begin
          if (!spi_rx_byte_i[7] && (spi_rx_byte_i != 8'h00)) begin
            fail      = 1'b1;
            fail_code = ERR_R1_NONZERO;
          end else if (spi_rx_byte_i[7] && (poll_cnt == R1_LAST)) begin
            fail      = 1'b1;
            fail_code = ERR_R1_TIMEOUT;
          end
        end
        ST_TOKEN_WAIT: begin
          if (spi_rx_byte_i == IDLE_BYTE) begin
            if (poll_cnt == TOKEN_LAST) begin
              fail      = 1'b1;
              fail_code = ERR_TOKEN;
            end
          end else if (spi_rx_byte_i != START_TOKEN) begin
            fail      = 1'b1;
            fail_code = ERR_TOKEN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge control_clk_i) begin
    if (control_rst_i) begin
      state         <= ST_IDLE;
      addr_lat      <= '0;
      byte_cnt      <= '0;
      poll_cnt      <= '0;
      outstanding   <= 1'b0;
      rd_busy_o     <= 1'b0;
      rd_done_o     <= 1'b0;
      rd_err_o      <= 1'b0;
      err_code_o    <= ERR_NONE;
      spi_cs_n_o    <= 1'b1;
      spi_start_o   <= 1'b0;
      spi_tx_byte_o <= IDLE_BYTE;
    end else begin
      spi_start_o <= 1'b0;
      rd_done_o   <= 1'b0;
      rd_err_o    <= 1'b0;
      // Cleared on completion; a new start in the same cycle overrides this.
      if (xfer_done) outstanding <= 1'b0;

      if (fail) begin
        spi_cs_n_o <= 1'b1;
        err_code_o <= fail_code;
        rd_err_o   <= 1'b1;
        rd_busy_o  <= 1'b0;
        state      <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rd_req_i) begin
              addr_lat      <= rd_addr_i;
              err_code_o    <= ERR_NONE;
              rd_busy_o     <= 1'b1;
              spi_cs_n_o    <= 1'b0;
              byte_cnt      <= '0;
              spi_start_o   <= 1'b1;
              spi_tx_byte_o <= CMD17_OP;
              outstanding   <= 1'b1;
              state         <= ST_CMD;
            end
          end

          ST_CMD: begin
            if (xfer_done) begin
              spi_start_o <= 1'b1;
              outstanding <= 1'b1;
              if (byte_cnt == CMD_LAST) begin
                spi_tx_byte_o <= IDLE_BYTE;
                poll_cnt      <= '0;
                state         <= ST_R1_WAIT;
              end else begin
                spi_tx_byte_o <= cmd_byte(next_cmd_idx, addr_lat, CMD17_CRC);
                byte_cnt      <= byte_cnt + 1'b1;
              end
            end
          end

          ST_R1_WAIT: begin
            if (xfer_done) begin
              spi_start_o   <= 1'b1;
              outstanding   <= 1'b1;
              spi_tx_byte_o <= IDLE_BYTE;
              if (spi_rx_byte_i == 8'h00) begin
                poll_cnt <= '0;
                state    <= ST_TOKEN_WAIT;
              end else begin
                poll_cnt <= poll_cnt + 1'b1;
              end
            end
          end

          ST_TOKEN_WAIT: begin
            if (xfer_done) begin
              spi_start_o   <= 1'b1;
              outstanding   <= 1'b1;
              spi_tx_byte_o <= IDLE_BYTE;
              if (spi_rx_byte_i == START_TOKEN) begin
                byte_cnt <= '0;
                state    <= ST_DATA;
              end else begin
                poll_cnt <= poll_cnt + 1'b1;
              end
            end
          end

          ST_DATA: begin
            if (xfer_done) begin
              spi_start_o   <= 1'b1;
              outstanding   <= 1'b1;
              spi_tx_byte_o <= IDLE_BYTE;
              if (byte_cnt == DATA_LAST) begin
                byte_cnt <= '0;
                state    <= ST_CRC;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end

          ST_CRC: begin
            if (xfer_done) begin
              spi_start_o   <= 1'b1;
              outstanding   <= 1'b1;
              spi_tx_byte_o <= IDLE_BYTE;
              if (byte_cnt == CRC_LAST) begin
                // Deselect before the trailing byte so the card sees
                // 8 clocks with CS high and releases MISO.
                byte_cnt   <= '0;
                spi_cs_n_o <= 1'b1;
                state      <= ST_FINISH;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
            end
          end

          ST_FINISH: begin
            if (xfer_done) begin
              rd_done_o <= 1'b1;
              rd_busy_o <= 1'b0;
              state     <= ST_IDLE;
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  sd_word_packer u_packer (
    .clk      (control_clk_i),
    .rst      (control_rst_i),
    .clr      (accept),
    .byte_vld (pack_vld),
    .byte_in  (spi_rx_byte_i),
    .mem_we   (mem_we_o),
    .mem_addr (mem_addr_o),
    .mem_data (mem_data_o)
  );

endmodule
